// File: rtl/uesprit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uesprit_pkg
// Description : Shared widths and framing-state encoding for the scalar
//               unitary-ESPRIT chain (framer, accumulator, correlator).
// Revision    : 1.0 - initial release
// ============================================================================
package uesprit_pkg;

    localparam int DEF_DIN_WIDTH = 16;
    localparam int DEF_CNT_WIDTH = 16;

    // Framing state: IDLE waits for the first accepted sample, RUN counts.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } frame_state_t;

endpackage : uesprit_pkg
`default_nettype wire

// File: rtl/sq_mag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sq_mag_pipe
// Description : 3-stage re^2 + im^2 datapath (input reg, products, sum) with a
//               sideband tag bus travelling in lock-step with each sample.
// Revision    : 1.0 - initial release
// ============================================================================
module sq_mag_pipe #(
    parameter int DIN_WIDTH  = 16,
    parameter int DOUT_WIDTH = 32,
    parameter int TAG_WIDTH  = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIN_WIDTH-1:0]  in_re,
    input  logic [DIN_WIDTH-1:0]  in_im,
    input  logic                  in_valid,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic [DOUT_WIDTH-1:0] out_pwr,
    output logic                  out_valid,
    output logic [TAG_WIDTH-1:0]  out_tag
);

    localparam int PROD_WIDTH = 2 * DIN_WIDTH;

    logic [DIN_WIDTH-1:0]  re_q, re_d, im_q, im_d;
    logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [TAG_WIDTH-1:0]  tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
    logic [PROD_WIDTH-1:0] sq_re_q, sq_re_d, sq_im_q, sq_im_d;
    logic [DOUT_WIDTH-1:0] pwr_q, pwr_d;
    logic signed [PROD_WIDTH-1:0] re_ext, im_ext;

    // Next-state for all three stages; squares are always non-negative and the
    // worst-case sum 2^(2*DIN_WIDTH-1) fits in PROD_WIDTH bits unsigned.
    always_comb begin
        re_d    = in_re;
        im_d    = in_im;
        v1_d    = in_valid;
        tag1_d  = in_tag;
        re_ext  = {{DIN_WIDTH{re_q[DIN_WIDTH-1]}}, re_q};
        im_ext  = {{DIN_WIDTH{im_q[DIN_WIDTH-1]}}, im_q};
        sq_re_d = re_ext * re_ext;
        sq_im_d = im_ext * im_ext;
        v2_d    = v1_q;
        tag2_d  = tag1_q;
        pwr_d   = DOUT_WIDTH'(sq_re_q) + DOUT_WIDTH'(sq_im_q);
        v3_d    = v2_q;
        tag3_d  = tag2_q;
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_q    <= '0;
            im_q    <= '0;
            v1_q    <= 1'b0;
            tag1_q  <= '0;
            sq_re_q <= '0;
            sq_im_q <= '0;
            v2_q    <= 1'b0;
            tag2_q  <= '0;
            pwr_q   <= '0;
            v3_q    <= 1'b0;
            tag3_q  <= '0;
        end else begin
            re_q    <= re_d;
            im_q    <= im_d;
            v1_q    <= v1_d;
            tag1_q  <= tag1_d;
            sq_re_q <= sq_re_d;
            sq_im_q <= sq_im_d;
            v2_q    <= v2_d;
            tag2_q  <= tag2_d;
            pwr_q   <= pwr_d;
            v3_q    <= v3_d;
            tag3_q  <= tag3_d;
        end
    end

    assign out_pwr   = pwr_q;
    assign out_valid = v3_q;
    assign out_tag   = tag3_q;

endmodule : sq_mag_pipe
`default_nettype wire

// File: rtl/mag2_framer.sv
`default_nettype none
// ============================================================================
// Module      : mag2_framer
// Description : Instantaneous power |x|^2 of a complex stream, framed into
//               groups of frame_len accepted samples; acc_done marks the first
//               sample of each frame so the downstream accumulator restarts.
// Revision    : 1.0 - initial release
// ============================================================================
module mag2_framer
    import uesprit_pkg::*;
#(
    parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
    parameter int DOUT_WIDTH = 2 * DIN_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIN_WIDTH-1:0]  din_re,
    input  logic [DIN_WIDTH-1:0]  din_im,
    input  logic                  din_valid,
    input  logic                  en,
    input  logic [CNT_WIDTH-1:0]  frame_len,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  acc_done,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

    localparam int TAG_WIDTH = CNT_WIDTH + 1;

    frame_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic                  accept;
    logic                  frame_start;
    logic                  last;
    logic [CNT_WIDTH-1:0]  eff_len;
    logic [TAG_WIDTH-1:0]  tag_in;
    logic [TAG_WIDTH-1:0]  tag_out;
    logic                  pipe_valid;

    assign accept = din_valid & en;

    // Framing next-state: a frame starts from IDLE or right after a wrap
    // (cnt back at 0); frame_len is only looked at on that start sample.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        frame_start = (state_q == ST_IDLE) || (cnt_q == '0);
        eff_len     = frame_start ? frame_len : len_q;
        last        = (eff_len < CNT_WIDTH'(2)) || (cnt_q == eff_len - CNT_WIDTH'(1));
        tag_in      = {frame_start, cnt_q};
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = ST_RUN;
            len_d   = eff_len;
            cnt_d   = last ? '0 : cnt_q + CNT_WIDTH'(1);
        end
    end

    // Framing state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    sq_mag_pipe #(
        .DIN_WIDTH  (DIN_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_re     (din_re),
        .in_im     (din_im),
        .in_valid  (accept),
        .in_tag    (tag_in),
        .out_pwr   (dout),
        .out_valid (pipe_valid),
        .out_tag   (tag_out)
    );

    // Sideband is only meaningful on valid beats, so it is masked otherwise.
    assign dout_valid = pipe_valid;
    assign acc_done   = pipe_valid & tag_out[CNT_WIDTH];
    assign frame_cnt  = pipe_valid ? tag_out[CNT_WIDTH-1:0] : '0;

endmodule : mag2_framer
`default_nettype wire

// File: tb/tb_mag2_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mag2_framer
// Description : Directed, table-driven bench for mag2_framer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mag2_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din_re = '0, din_im = '0;
    logic        din_valid = 1'b0, en = 1'b0;
    logic [15:0] frame_len = '0;
    logic [31:0] dout;
    logic        dout_valid, acc_done;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] d;
        logic        a;
        logic [15:0] c;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [31:0] exp_pwr;
    } pvec_t;

    beat_t obs[$];
    beat_t expq[$];
    pvec_t ptab[7];

    mag2_framer #(.DIN_WIDTH(16), .DOUT_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_re     (din_re),
        .din_im     (din_im),
        .din_valid  (din_valid),
        .en         (en),
        .frame_len  (frame_len),
        .dout       (dout),
        .dout_valid (dout_valid),
        .acc_done   (acc_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every valid output beat on the falling edge.
    always @(negedge clk) begin
        if (rst_n && dout_valid) begin
            beat_t b;
            b.d = dout; b.a = acc_done; b.c = frame_cnt; b.cyc = cyc;
            obs.push_back(b);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic e, input logic [15:0] re,
                         input logic [15:0] im, input logic [15:0] fl);
        din_valid = v; en = e; din_re = re; din_im = im; frame_len = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic a, input logic [15:0] c);
        beat_t b;
        b.d = d; b.a = a; b.c = c; b.cyc = 0;
        expq.push_back(b);
    endtask

    task automatic drain();
        repeat (6) drive(1'b0, 1'b1, 16'd0, 16'd0, frame_len);
    endtask

    task automatic compare_run(input string tag);
        int n;
        chk({tag, " beats"}, 64'(obs.size()), 64'(expq.size()));
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d] dout", tag, i), 64'(obs[i].d), 64'(expq[i].d));
            chk($sformatf("%s[%0d] acc_done", tag, i), 64'(obs[i].a), 64'(expq[i].a));
            chk($sformatf("%s[%0d] frame_cnt", tag, i), 64'(obs[i].c), 64'(expq[i].c));
        end
        obs.delete();
        expq.delete();
    endtask

    task automatic do_reset();
        din_valid = 1'b0; en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs.delete();
        expq.delete();
    endtask

    initial begin
        int in_cyc;
        int p;

        ptab[0] = '{16'sd3,      16'sd4,      32'd25};
        ptab[1] = '{16'h8000,    16'h8000,    32'h8000_0000};
        ptab[2] = '{16'h7FFF,    16'h0000,    32'h3FFF_0001};
        ptab[3] = '{16'h0000,    16'h0000,    32'h0000_0000};
        ptab[4] = '{16'hFFFF,    16'hFFFF,    32'd2};
        ptab[5] = '{16'h8000,    16'h7FFF,    32'h7FFF_0001};
        ptab[6] = '{16'd100,     16'hFF38,    32'd50000};

        // Reset state
        rst_n = 1'b0;
        #3;
        chk("reset dout", 64'(dout), 64'd0);
        chk("reset dout_valid", 64'(dout_valid), 64'd0);
        chk("reset acc_done", 64'(acc_done), 64'd0);
        chk("reset frame_cnt", 64'(frame_cnt), 64'd0);
        do_reset();

        // Back-to-back (3,4) with frame_len=4
        in_cyc = cyc;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 16'd3, 16'd4, 16'd4);
            expect_beat(32'd25, (i % 4) == 0, 16'(i % 4));
        end
        drain();
        if (obs.size() > 0)
            chk("latency", 64'(obs[0].cyc - in_cyc), 64'd3);
        else
            chk("latency no output", 64'd0, 64'd1);
        compare_run("len4");

        // Power table with frame_len=1: every beat starts a frame
        do_reset();
        foreach (ptab[i]) begin
            drive(1'b1, 1'b1, ptab[i].re, ptab[i].im, 16'd1);
            expect_beat(ptab[i].exp_pwr, 1'b1, 16'd0);
        end
        drain();
        compare_run("power");

        // frame_len=3 with din_valid toggling; bubbles never count
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 16'(i + 1), 16'd2, 16'd3);
            drive(1'b0, 1'b1, 16'd7, 16'd7, 16'd3);
            expect_beat(32'((i + 1) * (i + 1) + 4), (i % 3) == 0, 16'(i % 3));
        end
        drain();
        compare_run("bubbles");

        // frame_len 4 -> 2 on the 2nd sample: current frame still spans 4
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 16'd1, 16'd1, (i == 0) ? 16'd4 : 16'd2);
            p = (i < 4) ? i : (i - 4) % 2;
            expect_beat(32'd2, p == 0, 16'(p));
        end
        drain();
        compare_run("relen");

        // en drop after sample 2 of a 5-sample frame, re-raised 6 cycles later
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'd2, 16'd0, 16'd5);
            expect_beat(32'd4, i == 0, 16'(i));
        end
        repeat (6) drive(1'b1, 1'b0, 16'd9, 16'd9, 16'd5);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 16'd0, 16'd3, 16'd5);
            expect_beat(32'd9, i == 0, 16'(i));
        end
        drain();
        compare_run("en_drop");

        // Asynchronous reset with the pipe full
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 16'd3, 16'd4, 16'd4);
        chk("pre-reset dout_valid", 64'(dout_valid), 64'd1);
        rst_n = 1'b0;
        din_valid = 1'b0;
        #1;
        chk("async reset dout", 64'(dout), 64'd0);
        chk("async reset dout_valid", 64'(dout_valid), 64'd0);
        chk("async reset acc_done", 64'(acc_done), 64'd0);
        chk("async reset frame_cnt", 64'(frame_cnt), 64'd0);
        obs.delete();
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) drive(1'b0, 1'b1, 16'd0, 16'd0, 16'd4);
        chk("flushed samples emerged", 64'(obs.size()), 64'd0);
        obs.delete();
        drive(1'b1, 1'b1, 16'd5, 16'd12, 16'd4);
        expect_beat(32'd169, 1'b1, 16'd0);
        drain();
        compare_run("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_mag2_framer
`default_nettype wire
